// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - byte FIFO feeding the UART transmitter one frame at a time.
module uart_tx_fifo #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [7:0]            push_data,
    input  logic                  push_valid,
    output logic                  push_ready,
    output logic [7:0]            tx_byte,
    output logic                  tx_trigger,
    input  logic                  tx_ready,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overflow
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL = {1'b1, {DEPTH_LOG2{1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WAIT_BUSY = 2'd1,
        S_WAIT_DONE = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [7:0]            mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic [7:0]            tx_byte_q, tx_byte_d;
    logic                  tx_trigger_q, tx_trigger_d;
    logic                  overflow_q, overflow_d;
    logic                  push_acc;
    logic                  issue;

    assign push_ready = (count_q != FULL);
    assign push_acc   = push_valid && push_ready;
    // Issue decision uses the registered count, so a fresh push is seen a cycle later.
    assign issue      = (state_q == S_IDLE) && tx_ready && (count_q != '0);

    always_comb begin
        state_d      = state_q;
        rd_ptr_d     = rd_ptr_q;
        tx_byte_d    = tx_byte_q;
        tx_trigger_d = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (issue) begin
                    tx_byte_d    = mem_q[rd_ptr_q];
                    tx_trigger_d = 1'b1;
                    rd_ptr_d     = rd_ptr_q + 1'b1;
                    state_d      = S_WAIT_BUSY;
                end
            end
            S_WAIT_BUSY: begin
                if (!tx_ready) state_d = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (tx_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d   = push_acc ? wr_ptr_q + 1'b1 : wr_ptr_q;
        overflow_d = overflow_q | (push_valid && !push_ready);
        count_d    = count_q;
        unique case ({push_acc, issue})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            tx_byte_q    <= 8'h00;
            tx_trigger_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            tx_byte_q    <= tx_byte_d;
            tx_trigger_q <= tx_trigger_d;
            overflow_q   <= overflow_d;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset && push_acc) mem_q[wr_ptr_q] <= push_data;
    end

    assign tx_byte    = tx_byte_q;
    assign tx_trigger = tx_trigger_q;
    assign count      = count_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - randomized queue-model bench for uart_tx_fifo.
module tb_uart_tx_fifo;

    localparam int DL    = 4;
    localparam int DEPTH = 1 << DL;

    logic          clock = 1'b0;
    logic          reset;
    logic [7:0]    push_data;
    logic          push_valid;
    logic          push_ready;
    logic [7:0]    tx_byte;
    logic          tx_trigger;
    logic          tx_ready;
    logic [DL:0]   count;
    logic          overflow;

    uart_tx_fifo #(.DEPTH_LOG2(DL)) dut (
        .clock      (clock),
        .reset      (reset),
        .push_data  (push_data),
        .push_valid (push_valid),
        .push_ready (push_ready),
        .tx_byte    (tx_byte),
        .tx_trigger (tx_trigger),
        .tx_ready   (tx_ready),
        .count      (count),
        .overflow   (overflow)
    );

    always #5 clock = ~clock;

    int          n_checks = 0;
    int          n_pass   = 0;
    byte unsigned exp_q[$];
    bit          m_ovf      = 1'b0;
    int          phase      = 0;
    bit          prev_trig  = 1'b0;
    int          trig_total = 0;
    bit          auto_tx    = 1'b0;
    int          busy_left  = 0;
    int          frame_len  = 10;
    int          max_count  = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // One clock: predict from pre-edge inputs, sample 1ns after the edge, then
    // let the transmitter model react for the next cycle.
    task automatic step();
        bit           pv, rdy, rst, acc, exp_trig;
        byte unsigned pd;
        pv       = push_valid;
        pd       = push_data;
        rdy      = tx_ready;
        rst      = reset;
        acc      = pv && (exp_q.size() < DEPTH);
        exp_trig = !rst && phase == 0 && rdy && exp_q.size() > 0;
        @(posedge clock);
        #1;
        if (rst) begin
            exp_q.delete();
            m_ovf = 1'b0;
            phase = 0;
            check("rst_tx_byte", tx_byte, 0);
            check("rst_trigger", tx_trigger, 0);
        end else begin
            check("trigger", tx_trigger, exp_trig);
            check("no_back_to_back", tx_trigger && prev_trig, 0);
            if (tx_trigger) trig_total++;
            if (tx_trigger && exp_q.size() > 0) check("tx_byte", tx_byte, exp_q.pop_front());
            case (phase)
                0: if (exp_trig) phase = 1;
                1: if (!rdy) phase = 2;
                2: if (rdy) phase = 0;
                default: phase = 0;
            endcase
            if (acc) exp_q.push_back(pd);
            if (pv && !acc) m_ovf = 1'b1;
        end
        prev_trig = tx_trigger;
        check("count", count, exp_q.size());
        check("overflow", overflow, m_ovf);
        check("push_ready", push_ready, exp_q.size() < DEPTH);
        if (count > max_count) max_count = count;
        if (auto_tx) begin
            if (tx_trigger) begin
                tx_ready  = 1'b0;
                busy_left = frame_len;
            end else if (!tx_ready) begin
                if (busy_left > 0) busy_left--;
                else tx_ready = 1'b1;
            end
        end
    endtask

    task automatic drain(input int budget);
        int b;
        b = budget;
        while ((exp_q.size() > 0 || phase != 0) && b > 0) begin
            step();
            b--;
        end
        check("drain_done", exp_q.size(), 0);
    endtask

    initial begin
        int t0;
        reset      = 1'b1;
        push_valid = 1'b0;
        push_data  = 8'h00;
        tx_ready   = 1'b1;
        step();
        step();
        reset = 1'b0;
        step();
        check("idle_count", count, 0);
        check("idle_overflow", overflow, 0);

        // Single byte, first-byte latency and no retrigger
        auto_tx    = 1'b1;
        frame_len  = 10;
        push_data  = 8'h41;
        push_valid = 1'b1;
        step();
        push_valid = 1'b0;
        check("latency_not_early", tx_trigger, 0);
        step();
        check("first_latency", tx_trigger, 1);
        check("first_byte", tx_byte, 8'h41);
        repeat (400) step();
        check("single_trig_total", trig_total, 1);
        check("single_count", count, 0);

        // Five bytes held back, then released in order
        auto_tx  = 1'b0;
        tx_ready = 1'b0;
        t0 = trig_total;
        for (int i = 1; i <= 5; i++) begin
            push_data  = 8'(i);
            push_valid = 1'b1;
            step();
        end
        push_valid = 1'b0;
        step();
        check("held_count", count, 5);
        check("held_no_trig", trig_total - t0, 0);
        tx_ready  = 1'b1;
        auto_tx   = 1'b1;
        frame_len = 8;
        drain(500);
        check("five_trigs", trig_total - t0, 5);

        // Fill past full with random data
        auto_tx  = 1'b0;
        tx_ready = 1'b0;
        step();
        for (int i = 0; i < 17; i++) begin
            push_data  = 8'($urandom_range(0, 255));
            push_valid = 1'b1;
            step();
        end
        push_valid = 1'b0;
        check("full_count", count, 16);
        check("full_push_ready", push_ready, 0);
        check("full_overflow", overflow, 1);

        // Issue and refused push in the same cycle, then a push that fits
        t0         = trig_total;
        tx_ready   = 1'b1;
        auto_tx    = 1'b1;
        push_data  = 8'hEE;
        push_valid = 1'b1;
        step();
        check("full_issue_trig", trig_total - t0, 1);
        check("full_issue_count", count, 15);
        push_data = 8'h77;
        step();
        push_valid = 1'b0;
        check("refill_count", count, 16);
        drain(1500);

        // Wrap-around stream with concurrent pushes and pops
        frame_len = 3;
        max_count = 0;
        t0        = trig_total;
        for (int i = 0; i < 40; i++) begin
            push_data  = 8'(i);
            push_valid = 1'b1;
            step();
            push_valid = 1'b0;
            repeat ($urandom_range(2, 8)) step();
        end
        drain(800);
        check("wrap_trigs", trig_total - t0, 40);
        check("wrap_never_full", max_count < DEPTH, 1);

        // Reset while waiting for the transmitter to finish
        auto_tx  = 1'b0;
        tx_ready = 1'b0;
        step();
        for (int i = 0; i < 4; i++) begin
            push_data  = 8'hA0 + 8'(i);
            push_valid = 1'b1;
            step();
        end
        push_valid = 1'b0;
        frame_len  = 20;
        tx_ready   = 1'b1;
        auto_tx    = 1'b1;
        t0 = trig_total;
        for (int b = 0; b < 10 && trig_total == t0; b++) step();
        check("pre_reset_issue", trig_total - t0, 1);
        step();
        step();
        check("pre_reset_count", count, 3);
        reset = 1'b1;
        step();
        reset     = 1'b0;
        tx_ready  = 1'b1;
        busy_left = 0;
        check("post_reset_count", count, 0);
        check("post_reset_overflow", overflow, 0);
        t0 = trig_total;
        repeat (60) step();
        check("no_stale_bytes", trig_total - t0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
